mv_mult_seq: RTL and testbench

Parametrised sequential matrix-vector multiplier: computes c = A·b for an N×N matrix A and an N-element vector b. It uses a single time-shared multiply-accumulate unit, one product per clock. It replaces the fixed 3×3, row-per-cycle multiplier in the arithmetic datapath with selectable size, width and signedness. Operands are captured at start, and results are held stable between done pulses.

---
 rtl/mv_mult_seq.sv | 129 ++++++++++++
 tb/tb_mv_mult_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mv_mult_seq.sv
// Sequential matrix-vector multiplier: c = A*b using one shared multiply-accumulate unit,
// one product per clock. Operands are captured on start; c_flat changes only on done.
module mv_mult_seq #(
  parameter int unsigned N      = 3,
  parameter int unsigned DW     = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [N*N*DW-1:0]                a_flat,
  input  logic [N*DW-1:0]                  b_flat,
  output logic [N*(2*DW+$clog2(N))-1:0]    c_flat,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned ACC_W = 2 * DW + $clog2(N);
  localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [N*N*DW-1:0]    r_a;
  logic [N*DW-1:0]      r_b;
  logic [IW-1:0]        r_row;
  logic [IW-1:0]        r_col;
  logic [ACC_W-1:0]     r_acc;
  logic [N*ACC_W-1:0]   r_res;
  logic [N*ACC_W-1:0]   r_c;
  logic                 r_done;

  logic [DW-1:0]        w_a_el;
  logic [DW-1:0]        w_b_el;
  logic [2*DW-1:0]      w_a_ext;
  logic [2*DW-1:0]      w_b_ext;
  logic [2*DW-1:0]      w_prod;
  logic [ACC_W-1:0]     w_prod_ext;
  logic [ACC_W-1:0]     w_sum;
  logic                 w_last_col;
  logic                 w_last_row;

  assign w_a_el     = r_a[(int'(r_row) * N + int'(r_col)) * DW +: DW];
  assign w_b_el     = r_b[int'(r_col) * DW +: DW];
  assign w_last_col = (r_col == IW'(N - 1));
  assign w_last_row = (r_row == IW'(N - 1));

  // The low 2*DW bits of a 2*DW-wide product of extended operands equal the true product.
  if (SIGNED) begin : g_signed
    assign w_a_ext    = (2 * DW)'($signed(w_a_el));
    assign w_b_ext    = (2 * DW)'($signed(w_b_el));
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = ACC_W'($signed(w_prod));
  end else begin : g_unsigned
    assign w_a_ext    = (2 * DW)'(w_a_el);
    assign w_b_ext    = (2 * DW)'(w_b_el);
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = ACC_W'(w_prod);
  end

  assign w_sum = r_acc + w_prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (start) w_state_next = StRun;
      StRun:    if (w_last_col && w_last_row) w_state_next = StFinish;
      StFinish: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_acc  <= '0;
      r_res  <= '0;
      r_c    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a   <= a_flat;
            r_b   <= b_flat;
            r_row <= '0;
            r_col <= '0;
            r_acc <= '0;
          end
        end
        StRun: begin
          if (w_last_col) begin
            r_res[int'(r_row) * ACC_W +: ACC_W] <= w_sum;
            r_acc <= '0;
            r_col <= '0;
            if (!w_last_row) r_row <= r_row + IW'(1);
          end else begin
            r_acc <= w_sum;
            r_col <= r_col + IW'(1);
          end
        end
        StFinish: begin
          r_c    <= r_res;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // busy stays high through the done cycle even though the FSM is already idle.
  assign busy   = (r_state != StIdle) || r_done;
  assign done   = r_done;
  assign c_flat = r_c;

endmodule

// File: tb/tb_mv_mult_seq.sv
// Scoreboard bench for mv_mult_seq: four parameterisations, directed vectors,
// expected results queued at start and checked by a monitor on each done.
module tb_mv_mult_seq;

  typedef struct {
    logic [135:0] c;
    int           cyc;
  } exp_t;

  localparam int NN [4] = '{3, 3, 1, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st [4];
  logic bz [4];
  logic dn [4];
  logic [135:0] cv [4];

  logic [71:0]  a0, a1;
  logic [23:0]  b0, b1;
  logic [53:0]  c0, c1;
  logic [3:0]   a2, b2;
  logic [7:0]   c2;
  logic [255:0] a3;
  logic [63:0]  b3;
  logic [135:0] c3;

  exp_t q0[$], q1[$], q2[$], q3[$];
  int   n_run = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   fin = 1'b0;
  int   bcnt [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mv_mult_seq #(.N(3), .DW(8), .SIGNED(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a_flat(a0), .b_flat(b0),
    .c_flat(c0), .busy(bz[0]), .done(dn[0])
  );
  mv_mult_seq #(.N(3), .DW(8), .SIGNED(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a_flat(a1), .b_flat(b1),
    .c_flat(c1), .busy(bz[1]), .done(dn[1])
  );
  mv_mult_seq #(.N(1), .DW(4), .SIGNED(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a_flat(a2), .b_flat(b2),
    .c_flat(c2), .busy(bz[2]), .done(dn[2])
  );
  mv_mult_seq #(.N(4), .DW(16), .SIGNED(1'b0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .a_flat(a3), .b_flat(b3),
    .c_flat(c3), .busy(bz[3]), .done(dn[3])
  );

  assign cv[0] = 136'(c0);
  assign cv[1] = 136'(c1);
  assign cv[2] = 136'(c2);
  assign cv[3] = c3;

  function automatic logic [135:0] p3(input int v0, input int v1, input int v2);
    return 136'({18'(v2), 18'(v1), 18'(v0)});
  endfunction

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_exp(input int d, output bit ok, output exp_t e);
    ok = 1'b0;
    e.c = '0;
    e.cyc = 0;
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Issue one start pulse; the done edge is expected N*N+1 edges after the sampling edge.
  task automatic go(input int d, input logic [135:0] c, input bit push);
    exp_t e;
    @(negedge clk);
    st[d] = 1'b1;
    e.c = c;
    e.cyc = cyc + 2 + NN[d] * NN[d];
    if (push) begin
      case (d)
        0: q0.push_back(e);
        1: q1.push_back(e);
        2: q2.push_back(e);
        default: q3.push_back(e);
      endcase
    end
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int k = 0;
    while (bz[d] && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (bz[d]) begin
      $display("FAIL idle_timeout dut%0d: busy=1 after %0d cycles, expected 0", d, k);
      $fatal(1, "bench stopped on timeout");
    end
  endtask

  // Monitor: reset values while rst_n is low, scoreboard pops on done, busy length on fall.
  always begin
    exp_t e;
    bit   ok;
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("rst_c%0d", d), cv[d], '0);
        chk($sformatf("rst_busy%0d", d), 136'(bz[d]), '0);
        chk($sformatf("rst_done%0d", d), 136'(dn[d]), '0);
        bcnt[d] = 0;
      end
    end else if (fin) begin
      chk("q_left0", 136'(q0.size()), '0);
      chk("q_left1", 136'(q1.size()), '0);
      chk("q_left2", 136'(q2.size()), '0);
      chk("q_left3", 136'(q3.size()), '0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (dn[d]) begin
          pop_exp(d, ok, e);
          if (!ok) begin
            n_run++;
            n_fail++;
            $display("FAIL spurious_done dut%0d: done=1 at cycle %0d, expected no done", d, cyc);
          end else begin
            chk($sformatf("c_dut%0d", d), cv[d], e.c);
            chk($sformatf("done_cyc_dut%0d", d), 136'(cyc), 136'(e.cyc));
          end
        end
        if (bz[d]) begin
          bcnt[d]++;
        end else if (bcnt[d] != 0) begin
          chk($sformatf("busy_len_dut%0d", d), 136'(bcnt[d]), 136'(NN[d] * NN[d] + 2));
          bcnt[d] = 0;
        end
      end
    end
  end

  localparam logic [71:0] Ident = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};

  initial begin
    for (int d = 0; d < 4; d++) st[d] = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    a2 = '0; b2 = '0; a3 = '0; b3 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Identity, unsigned
    a0 = Ident;
    b0 = {8'd3, 8'd2, 8'd1};
    go(0, p3(1, 2, 3), 1'b1);
    wait_idle(0);

    // All-ones unsigned worst case
    a0 = '1;
    b0 = '1;
    go(0, p3(195075, 195075, 195075), 1'b1);
    wait_idle(0);

    // Signed worst case and mixed-sign rows
    a1 = {9{8'h80}};
    b1 = {3{8'h80}};
    go(1, p3(49152, 49152, 49152), 1'b1);
    wait_idle(1);
    a1 = {8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0, 8'hFD, 8'd2, 8'hFF};
    b1 = {8'd6, 8'd5, 8'd4};
    go(1, p3(-12, 5, 15), 1'b1);
    wait_idle(1);

    // Operands change and start is held high while busy, through the finish edge
    a0 = Ident;
    b0 = {8'd9, 8'd8, 8'd7};
    go(0, p3(7, 8, 9), 1'b1);
    st[0] = 1'b1;
    a0 = '1;
    b0 = '1;
    repeat (10) @(negedge clk);
    st[0] = 1'b0;
    wait_idle(0);
    go(0, p3(195075, 195075, 195075), 1'b1);
    wait_idle(0);

    // Asynchronous reset in the middle of RUN; the aborted run must not signal done
    a0 = Ident;
    b0 = {8'd3, 8'd2, 8'd1};
    go(0, p3(1, 2, 3), 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    go(0, p3(1, 2, 3), 1'b1);
    wait_idle(0);

    // N=1, DW=4
    a2 = 4'd15;
    b2 = 4'd15;
    go(2, 136'(8'd225), 1'b1);
    wait_idle(2);

    // N=4, DW=16
    a3 = {{4{16'hFFFF}},
          16'd12, 16'd11, 16'd10, 16'd9,
          16'd8,  16'd7,  16'd6,  16'd5,
          16'd4,  16'd3,  16'd2,  16'd1};
    b3 = {16'hFFFF, 16'd1, 16'd1, 16'd1};
    go(3, {34'd4295032830, 34'd786450, 34'd524298, 34'd262146}, 1'b1);
    wait_idle(3);

    repeat (5) @(negedge clk);
    fin = 1'b1;
  end

endmodule
